uart_rx_buffer: RTL and testbench
=================================

# uart_rx_buffer

Receive-side buffer that sits directly downstream of the UART core. It captures each byte the core flags as received and acknowledges it with a one-cycle pulse. Bytes are queued in a first-word-fall-through FIFO and handed to the host side over a valid/ready interface. It also tracks core framing errors and FIFO overflow as sticky status for the register block.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥ 2.
- AW, $clog2(DEPTH): pointer width (derived; do not override).
- clk  in  1  master clock, same clock as the UART core.
- rst_n  in  1  asynchronous, active-low reset.
- uart_received  in  1  core "byte received" level; held until acknowledged.
- uart_rx_byte  in  8  core received byte; valid while uart_received=1.
- uart_recv_error  in  1  core framing-error level; held until acknowledged.
- uart_recv_ack  out  1  one-cycle acknowledge to the core; clears both flags.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  8  head byte; 8'h00 when empty.
- rd_ready  in  1  host pops the head when rd_valid & rd_ready.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a received byte was dropped because the FIFO was full.
- err_count  out  8  saturating count of framing errors.
- clr_status  in  1  clears overflow and err_count.

## Operation
- Capture FSM states: CAP_IDLE, CAP_ACK.
- In CAP_IDLE, the FSM acts when uart_received | uart_recv_error:
  - If uart_received, push uart_rx_byte; drop it and set overflow if no push slot.
  - If uart_recv_error, increment err_count, saturating at 255.
  - Both flags high in the same cycle: do both actions; a single ack covers both.
  - Then go to CAP_ACK.
- In CAP_ACK: uart_recv_ack=1; the flags are ignored (the core still shows them this cycle); return to CAP_IDLE.
- Push slot exists if count<DEPTH or a pop occurs in the same cycle. When full, simultaneous push and pop both happen and count stays DEPTH.
- Pop when rd_valid & rd_ready; ignored when empty.
- Pointers are AW bits and wrap naturally. count is updated as +push −pop.
- clr_status: overflow←0, err_count←0. If an event occurs in the same cycle, the event wins: overflow←1, or err_count←1.
- FIFO storage is not reset. rd_data is forced to 0 when empty.

## Timing
- Reset values:
  - uart_recv_ack=0, rd_valid=0, rd_data=0, count=0, overflow=0, err_count=0.
  - FSM=CAP_IDLE, pointers=0.
- Capture latency:
  - uart_received high in cycle N → byte written at the end of N; rd_valid=1 in N+1 (if previously empty).
  - uart_recv_ack=1 in N+1 only; the core drops the flags at the end of N+1.
- Minimum capture spacing is 2 cycles. The core's byte period is far longer, so no byte is missed.
- Pop: the head advances at the edge where rd_valid & rd_ready. The new rd_data is valid in the next cycle (combinational read).
- Reset mid-operation: all state clears immediately and any pending ack is lost. A flag still held by the core is captured again after reset release. This is intended.
- Status outputs update one cycle after the triggering event.

## Structure
- Shared package uart_pkg:
  - cap_state_t enum {CAP_IDLE, CAP_ACK}.
  - UART_RX_FIFO_DEPTH default constant.
  - ERR_COUNT_MAX = 8'hFF.
- One sub-module: uart_sync_fifo.
  - Parameterised DEPTH/width 8, FWFT.
  - Ports: push, push_data, pop, rd_data, empty, full, count.
- The capture FSM and status counters live in the top level.

## Test plan
- Single byte: pulse uart_received with 8'hA5 held until ack.
  - Expect one uart_recv_ack pulse, one cycle after the flag rises.
  - Expect rd_valid=1, rd_data=8'hA5, count=1; pop → count=0, rd_data=0.
- Fill to overflow: 17 bytes 8'h00..8'h10 with rd_ready=0 (DEPTH=16).
  - Expect count=16 and overflow=1.
  - Reads return 8'h00..8'h0F in order; 8'h10 is lost; every byte is still acked.
- Full with simultaneous pop: count=16, rd_ready=1 as a new byte arrives.
  - Expect no overflow, count stays 16, and the new byte appears last.
- Errors: 3 uart_recv_error events → err_count=3.
  - 260 events → err_count=255.
  - clr_status in the same cycle as an error → err_count=1.
- Both flags together: received=1, error=1, byte 8'h3C in the same cycle.
  - Expect one ack, 8'h3C queued, err_count incremented by 1.
- Async reset with 5 bytes queued and the FSM in CAP_ACK.
  - Expect all outputs at reset values immediately.
  - A still-held uart_received is captured once after release.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
//   cap_state_t         capture FSM states
//   UART_RX_FIFO_DEPTH  default receive FIFO depth
//   ERR_COUNT_MAX       saturation value of the framing-error counter
package uart_pkg;

  typedef enum logic [0:0] {
    CAP_IDLE = 1'b0,
    CAP_ACK  = 1'b1
  } cap_state_t;

  localparam int UART_RX_FIFO_DEPTH = 16;

  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through byte FIFO
//   clk, rst_n   clock, asynchronous active-low reset (pointers/count only)
//   push         write push_data (ignored when full unless popping too)
//   push_data    byte to write
//   pop          advance head (ignored when empty)
//   rd_data      head byte, 8'h00 when empty
//   empty, full  occupancy flags
//   count        occupancy, 0..DEPTH
module uart_sync_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  assign do_pop  = pop & ~empty;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);

  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - UART receive capture, byte FIFO and sticky status
//   clk, rst_n        clock, asynchronous active-low reset
//   uart_received     core byte-received level, held until acked
//   uart_rx_byte      core received byte
//   uart_recv_error   core framing-error level, held until acked
//   uart_recv_ack     one-cycle acknowledge to the core
//   rd_valid/rd_data/rd_ready  host read side (FWFT, rd_data=0 when empty)
//   count             FIFO occupancy
//   overflow          sticky: byte dropped on full FIFO
//   err_count         saturating framing-error count
//   clr_status        clears overflow and err_count (events win)
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_RX_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          uart_received,
  input  logic [7:0]    uart_rx_byte,
  input  logic          uart_recv_error,
  output logic          uart_recv_ack,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  input  logic          rd_ready,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    err_count,
  input  logic          clr_status
);

  cap_state_t state;
  cap_state_t state_next;
  logic       capture;
  logic       ack;

  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push_req;
  logic       push;
  logic       drop;
  logic       err_event;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CAP_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The core keeps its flags up during CAP_ACK, so that state must not
  // look at them or the same byte would be captured twice.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    ack        = 1'b0;
    case (state)
      CAP_IDLE: begin
        if (uart_received | uart_recv_error) begin
          capture    = 1'b1;
          state_next = CAP_ACK;
        end
      end
      CAP_ACK: begin
        ack        = 1'b1;
        state_next = CAP_IDLE;
      end
      default: state_next = CAP_IDLE;
    endcase
  end

  assign uart_recv_ack = ack;

  assign rd_valid  = ~fifo_empty;
  assign pop       = rd_valid & rd_ready;
  assign push_req  = capture & uart_received;
  assign push      = push_req & (~fifo_full | pop);
  assign drop      = push_req & fifo_full & ~pop;
  assign err_event = capture & uart_recv_error;

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (uart_rx_byte),
    .pop       (pop),
    .rd_data   (rd_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (count)
  );

  // Status: a same-cycle event takes priority over clr_status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      err_count <= 8'h00;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_status) begin
        overflow <= 1'b0;
      end

      if (err_event) begin
        if (clr_status) begin
          err_count <= 8'h01;
        end else if (err_count != ERR_COUNT_MAX) begin
          err_count <= err_count + 8'h01;
        end
      end else if (clr_status) begin
        err_count <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - directed self-checking bench for uart_rx_buffer
module tb_uart_rx_buffer;

  logic       clk;
  logic       rst_n;
  logic       uart_received;
  logic [7:0] uart_rx_byte;
  logic       uart_recv_error;
  logic       uart_recv_ack;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] err_count;
  logic       clr_status;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ack_seen = 0;

  uart_rx_buffer #(.DEPTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .uart_received   (uart_received),
    .uart_rx_byte    (uart_rx_byte),
    .uart_recv_error (uart_recv_error),
    .uart_recv_ack   (uart_recv_ack),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .rd_ready        (rd_ready),
    .count           (count),
    .overflow        (overflow),
    .err_count       (err_count),
    .clr_status      (clr_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One core event: flags raised for the capture edge, ack expected in the
  // following cycle only, flags dropped after the ack cycle.
  task automatic core_event(input logic rcv, input logic err, input logic [7:0] b,
                            input logic rdy, input logic clr);
    uart_received   = rcv;
    uart_recv_error = err;
    uart_rx_byte    = b;
    rd_ready        = rdy;
    clr_status      = clr;
    tick();
    rd_ready   = 1'b0;
    clr_status = 1'b0;
    if (uart_recv_ack) ack_seen++;
    tick();
    if (uart_recv_ack) ack_seen++;
    uart_received   = 1'b0;
    uart_recv_error = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    uart_received   = 1'b0;
    uart_rx_byte    = 8'h00;
    uart_recv_error = 1'b0;
    rd_ready        = 1'b0;
    clr_status      = 1'b0;
    tick();
    tick();

    check("rst_ack", uart_recv_ack, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", err_count, 0);
    rst_n = 1'b1;
    tick();

    // Single byte
    uart_received = 1'b1;
    uart_rx_byte  = 8'hA5;
    #2;
    check("single_ack_before", uart_recv_ack, 0);
    tick();
    check("single_ack_n1", uart_recv_ack, 1);
    check("single_valid", rd_valid, 1);
    check("single_data", rd_data, 8'hA5);
    check("single_count", count, 1);
    tick();
    check("single_ack_n2", uart_recv_ack, 0);
    uart_received = 1'b0;
    tick();
    check("single_no_recapture", count, 1);
    pop_one();
    check("single_pop_count", count, 0);
    check("single_pop_data", rd_data, 0);
    check("single_pop_valid", rd_valid, 0);

    // Fill to overflow
    ack_seen = 0;
    for (int i = 0; i < 17; i++) begin
      core_event(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    end
    check("fill_acks", ack_seen, 17);
    check("fill_count", count, 16);
    check("fill_ovf", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill_rd%0d", i), rd_data, i);
      pop_one();
    end
    check("fill_drained", count, 0);
    check("fill_empty_data", rd_data, 0);

    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_ovf", overflow, 0);

    // Full with simultaneous pop
    for (int i = 0; i < 16; i++) begin
      core_event(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
    end
    check("fp_full", count, 16);
    core_event(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    check("fp_no_ovf", overflow, 0);
    check("fp_count", count, 16);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("fp_rd%0d", i), rd_data, 8'h20 + i);
      pop_one();
    end
    check("fp_last", rd_data, 8'h55);
    pop_one();
    check("fp_drained", count, 0);

    // Errors
    for (int i = 0; i < 3; i++) begin
      core_event(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    end
    check("err_three", err_count, 3);
    check("err_no_push", count, 0);
    for (int i = 0; i < 257; i++) begin
      core_event(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    end
    check("err_sat", err_count, 255);
    core_event(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    check("err_clr_event", err_count, 1);

    // Both flags together
    ack_seen = 0;
    core_event(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    check("both_acks", ack_seen, 1);
    check("both_count", count, 1);
    check("both_data", rd_data, 8'h3C);
    check("both_err", err_count, 2);
    pop_one();

    // Async reset mid-operation
    for (int i = 0; i < 5; i++) begin
      core_event(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
    end
    uart_received = 1'b1;
    uart_rx_byte  = 8'h77;
    tick();
    check("ar_pre_ack", uart_recv_ack, 1);
    check("ar_pre_count", count, 6);
    rst_n = 1'b0;
    #1;
    check("ar_ack", uart_recv_ack, 0);
    check("ar_valid", rd_valid, 0);
    check("ar_data", rd_data, 0);
    check("ar_count", count, 0);
    check("ar_ovf", overflow, 0);
    check("ar_err", err_count, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("ar_recap_count", count, 1);
    check("ar_recap_data", rd_data, 8'h77);
    check("ar_recap_ack", uart_recv_ack, 1);
    tick();
    check("ar_ack_done", uart_recv_ack, 0);
    uart_received = 1'b0;
    tick();
    check("ar_once", count, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
